// File: rtl/hazard_fwd_unit.sv
// Forwarding-select and front-end stall generation for the 5-stage pipeline.
// Tracks the EX/MEM destinations and owns the forwarding bits of the ID/EX register.
module hazard_fwd_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_vld,
    input  logic [4:0]       ID_rs1_addr,
    input  logic [4:0]       ID_rs2_addr,
    input  logic             ID_rs1_used,
    input  logic             ID_rs2_used,
    input  logic [4:0]       ID_rd_addr,
    input  logic             ID_rd_wr,
    input  logic             ID_is_load,
    input  logic             EX_alu_busy,
    input  logic             EX_take_br,
    output logic [5:0]       HZ_fwd_sel,
    output logic             HZ_stall,
    output logic [CNT_W-1:0] HZ_ldu_cnt
);

    localparam logic [2:0] F0 = 3'd0;  // register file
    localparam logic [2:0] F1 = 3'd1;  // MEM_data
    localparam logic [2:0] F2 = 3'd2;  // WB_data

    logic             r_ex_v;
    logic             r_ex_ld;
    logic [4:0]       r_ex_rd;
    logic             r_mem_v;
    logic [4:0]       r_mem_rd;
    logic [5:0]       r_fwd_sel;
    logic [CNT_W-1:0] r_ldu_cnt;

    logic       w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
    logic [2:0] w_sel_rs1, w_sel_rs2;
    logic       w_ldu;
    logic       w_id_wr;

    // A frozen EX stage still sees its producers move one stage further each edge.
    function automatic logic [2:0] age_sel(input logic [2:0] s);
        return (s == F1) ? F2 : F0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign w_ex_m1  = r_ex_v  & (r_ex_rd  == ID_rs1_addr) & ID_rs1_used;
    assign w_ex_m2  = r_ex_v  & (r_ex_rd  == ID_rs2_addr) & ID_rs2_used;
    assign w_mem_m1 = r_mem_v & (r_mem_rd == ID_rs1_addr) & ID_rs1_used;
    assign w_mem_m2 = r_mem_v & (r_mem_rd == ID_rs2_addr) & ID_rs2_used;

    assign w_sel_rs1 = w_ex_m1 ? F1 : (w_mem_m1 ? F2 : F0);
    assign w_sel_rs2 = w_ex_m2 ? F1 : (w_mem_m2 ? F2 : F0);

    assign w_ldu   = ID_vld & r_ex_v & r_ex_ld & (w_ex_m1 | w_ex_m2);
    assign w_id_wr = ID_vld & ID_rd_wr & (ID_rd_addr != 5'd0);

    assign HZ_stall   = EX_alu_busy | (w_ldu & ~EX_take_br);
    assign HZ_fwd_sel = r_fwd_sel;
    assign HZ_ldu_cnt = r_ldu_cnt;

    // Control state: valids, selects and the stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_v    <= 1'b0;
            r_mem_v   <= 1'b0;
            r_fwd_sel <= 6'd0;
            r_ldu_cnt <= '0;
        end else if (EX_alu_busy) begin
            r_mem_v   <= 1'b0;
            r_fwd_sel <= {age_sel(r_fwd_sel[5:3]), age_sel(r_fwd_sel[2:0])};
        end else if (EX_take_br || w_ldu) begin
            r_mem_v   <= r_ex_v;
            r_ex_v    <= 1'b0;
            r_fwd_sel <= 6'd0;
            if (!EX_take_br)
                r_ldu_cnt <= sat_inc(r_ldu_cnt);
        end else begin
            r_mem_v   <= r_ex_v;
            r_ex_v    <= w_id_wr;
            r_fwd_sel <= {w_sel_rs1, w_sel_rs2};
        end
    end

    // Destination fields are qualified by the valids, so they need no reset.
    always_ff @(posedge clk) begin
        if (!EX_alu_busy) begin
            r_mem_rd <= r_ex_rd;
            if (!(EX_take_br || w_ldu)) begin
                r_ex_rd <= ID_rd_addr;
                r_ex_ld <= ID_is_load;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed and randomized bench for hazard_fwd_unit against a pipeline-occupancy model.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       ID_vld, ID_rs1_used, ID_rs2_used, ID_rd_wr, ID_is_load;
    logic [4:0] ID_rs1_addr, ID_rs2_addr, ID_rd_addr;
    logic       EX_alu_busy, EX_take_br;
    logic [5:0] HZ_fwd_sel, sat_sel;
    logic       HZ_stall, sat_stall;
    logic [15:0] HZ_ldu_cnt;
    logic [3:0]  sat_cnt;

    int total = 0;
    int bad   = 0;
    logic last_stall;

    // Model: slot 0 = instruction in EX, slot 1 = instruction in MEM.
    bit       pv[2];
    bit [4:0] prd[2];
    bit       pld[2];
    int       m_s1, m_s2;
    int       m_cnt;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ID_vld(ID_vld),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
        .ID_rd_addr(ID_rd_addr), .ID_rd_wr(ID_rd_wr), .ID_is_load(ID_is_load),
        .EX_alu_busy(EX_alu_busy), .EX_take_br(EX_take_br),
        .HZ_fwd_sel(HZ_fwd_sel), .HZ_stall(HZ_stall), .HZ_ldu_cnt(HZ_ldu_cnt)
    );

    hazard_fwd_unit #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .ID_vld(ID_vld),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
        .ID_rd_addr(ID_rd_addr), .ID_rd_wr(ID_rd_wr), .ID_is_load(ID_is_load),
        .EX_alu_busy(EX_alu_busy), .EX_take_br(EX_take_br),
        .HZ_fwd_sel(sat_sel), .HZ_stall(sat_stall), .HZ_ldu_cnt(sat_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Nearest in-flight writer of the address wins; distance d maps to select d+1.
    function automatic int src_sel(input bit [4:0] a, input bit used);
        for (int d = 0; d < 2; d++)
            if (used && pv[d] && prd[d] == a) return d + 1;
        return 0;
    endfunction

    function automatic bit m_ldu();
        return ID_vld && pv[0] && pld[0] &&
               (src_sel(ID_rs1_addr, ID_rs1_used) == 1 || src_sel(ID_rs2_addr, ID_rs2_used) == 1);
    endfunction

    function automatic int age(input int s);
        return (s == 0 || s + 1 > 2) ? 0 : s + 1;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        pv[0] = 0; pv[1] = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit ldu;
        ldu = m_ldu();
        if (EX_alu_busy) begin
            pv[1] = 0;
            m_s1 = age(m_s1);
            m_s2 = age(m_s2);
        end else if (EX_take_br || ldu) begin
            pv[1] = pv[0]; prd[1] = prd[0]; pld[1] = pld[0];
            pv[0] = 0;
            m_s1 = 0; m_s2 = 0;
            if (!EX_take_br) m_cnt++;
        end else begin
            m_s1 = src_sel(ID_rs1_addr, ID_rs1_used);
            m_s2 = src_sel(ID_rs2_addr, ID_rs2_used);
            pv[1] = pv[0]; prd[1] = prd[0]; pld[1] = pld[0];
            pv[0] = ID_vld && ID_rd_wr && ID_rd_addr != 0;
            prd[0] = ID_rd_addr; pld[0] = ID_is_load;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_sel"}, HZ_fwd_sel, m_s1 * 8 + m_s2);
        check({tag, "_cnt"}, HZ_ldu_cnt, sat(m_cnt, 65535));
        check({tag, "_sat_sel"}, sat_sel, m_s1 * 8 + m_s2);
        check({tag, "_sat_cnt"}, sat_cnt, sat(m_cnt, 15));
    endtask

    task automatic step(input logic vld, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic busy, input logic br);
        bit exp_stall;
        @(negedge clk);
        ID_vld = vld; ID_rs1_addr = rs1; ID_rs1_used = u1; ID_rs2_addr = rs2;
        ID_rs2_used = u2; ID_rd_addr = rd; ID_rd_wr = wr; ID_is_load = ld;
        EX_alu_busy = busy; EX_take_br = br;
        #1;
        exp_stall = busy || (m_ldu() && !br);
        check("stall", HZ_stall, exp_stall);
        check("sat_stall", sat_stall, exp_stall);
        last_stall = HZ_stall;
        @(posedge clk);
        model_edge();
        #1;
        check_regs("step");
    endtask

    initial begin
        rst = 1'b1;
        ID_vld = 0; ID_rs1_addr = 0; ID_rs2_addr = 0; ID_rs1_used = 0; ID_rs2_used = 0;
        ID_rd_addr = 0; ID_rd_wr = 0; ID_is_load = 0; EX_alu_busy = 0; EX_take_br = 0;
        model_reset();
        #12 rst = 1'b0;
        #1;
        check("reset_sel", HZ_fwd_sel, 0);
        check("reset_cnt", HZ_ldu_cnt, 0);
        check("reset_stall", HZ_stall, 0);

        // addi x5,x0,1 ; add x6,x5,x1
        step(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        check("dist1", HZ_fwd_sel, 6'b001_000);
        check("dist1_stall", last_stall, 0);

        step(1, 0, 1, 0, 0, 9, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 10, 1, 0, 0, 0);
        step(1, 9, 1, 1, 1, 11, 1, 0, 0, 0);
        check("dist2", HZ_fwd_sel, 6'b010_000);

        step(1, 0, 1, 0, 0, 12, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 13, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 14, 1, 0, 0, 0);
        step(1, 12, 1, 1, 1, 15, 1, 0, 0, 0);
        check("dist3", HZ_fwd_sel, 6'b000_000);

        step(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        step(1, 5, 1, 5, 1, 16, 1, 0, 0, 0);
        check("ex_prio", HZ_fwd_sel, 6'b001_001);

        // lw x7 ; add x8,x7,x7
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 0);
        check("ldu_stall", last_stall, 1);
        check("ldu_bubble", HZ_fwd_sel, 6'b000_000);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 0);
        check("ldu_release", last_stall, 0);
        check("ldu_sel", HZ_fwd_sel, 6'b010_010);
        check("ldu_cnt", HZ_ldu_cnt, 1);

        // EX select {F1,F2}, then three busy edges
        step(1, 0, 1, 0, 0, 3, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 4, 1, 0, 0, 0);
        step(1, 4, 1, 3, 1, 20, 1, 0, 0, 0);
        check("busy_pre", HZ_fwd_sel, 6'b001_010);
        step(1, 20, 1, 4, 1, 21, 1, 0, 1, 0);
        check("busy1", HZ_fwd_sel, 6'b010_000);
        check("busy1_stall", last_stall, 1);
        step(1, 20, 1, 4, 1, 21, 1, 0, 1, 0);
        check("busy2", HZ_fwd_sel, 6'b000_000);
        step(1, 20, 1, 4, 1, 21, 1, 0, 1, 0);
        check("busy3", HZ_fwd_sel, 6'b000_000);
        check("busy3_stall", last_stall, 1);
        step(1, 20, 1, 4, 1, 21, 1, 0, 0, 0);
        check("busy_drop", HZ_fwd_sel, 6'b001_000);

        // x0 producer, then flush coinciding with a load-use
        step(1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        check("x0", HZ_fwd_sel, 6'b000_000);
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 1);
        check("br_ldu_stall", last_stall, 0);
        check("br_ldu_sel", HZ_fwd_sel, 6'b000_000);
        check("br_ldu_cnt", HZ_ldu_cnt, 1);

        // async reset between edges while busy
        step(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        @(negedge clk);
        ID_vld = 1; ID_rs1_addr = 5; ID_rs1_used = 1; ID_rs2_used = 0; ID_rd_addr = 6;
        ID_is_load = 0; EX_take_br = 0; EX_alu_busy = 1;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("arst_sel", HZ_fwd_sel, 0);
        check("arst_cnt", HZ_ldu_cnt, 0);
        check("arst_stall", HZ_stall, 1);
        #1 rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check_regs("arst_post");

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 1),
                 5'($urandom_range(0, 7)), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
